// File: rtl/muldiv_unit_if.sv
// Request/response bundle between the issue stage and the iterative multiply/divide unit.
// The requester drives operands and control; the unit returns status and write-back fields.
interface muldiv_unit_if #(
  parameter int unsigned D_WIDTH = 32,
  parameter int unsigned A_WIDTH = 5
);
  logic               start;
  logic [2:0]         funct3;
  logic [D_WIDTH-1:0] op_a;
  logic [D_WIDTH-1:0] op_b;
  logic [A_WIDTH-1:0] rd_in;
  logic               flush;
  logic               busy;
  logic               done;
  logic [D_WIDTH-1:0] result;
  logic [A_WIDTH-1:0] rd_out;
  logic               reg_write;

  modport master (
    output start, funct3, op_a, op_b, rd_in, flush,
    input  busy, done, result, rd_out, reg_write
  );

  modport slave (
    input  start, funct3, op_a, op_b, rd_in, flush,
    output busy, done, result, rd_out, reg_write
  );
endinterface

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide: radix-2 shift-add multiply and restoring divide,
// fixed D_WIDTH+1 cycle latency, one operation in flight, registered write-back outputs.
module muldiv_unit #(
  parameter int unsigned D_WIDTH = 32,
  parameter int unsigned A_WIDTH = 5
) (
  input logic          clk,
  input logic          rst_n,
  muldiv_unit_if.slave bus
);
  localparam int unsigned P_WIDTH = 2 * D_WIDTH;
  localparam int unsigned CNT_W   = $clog2(D_WIDTH);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t             state;
  logic [CNT_W-1:0]   count;
  logic [2:0]         op;
  logic               sign_a;
  logic               sign_b;
  logic               b_zero;
  logic [D_WIDTH-1:0] opnd;
  logic [P_WIDTH-1:0] acc;
  logic               busy_q;
  logic               done_q;
  logic               reg_write_q;
  logic [D_WIDTH-1:0] result_q;
  logic [A_WIDTH-1:0] rd_q;

  // Operand signedness and magnitudes of the incoming request
  logic               is_div;
  logic               neg_a;
  logic               neg_b;
  logic [D_WIDTH-1:0] mag_a;
  logic [D_WIDTH-1:0] mag_b;

  always_comb begin
    is_div = bus.funct3[2];
    neg_a  = 1'b0;
    neg_b  = 1'b0;
    if (is_div) begin
      neg_a = ~bus.funct3[0] & bus.op_a[D_WIDTH-1];
      neg_b = ~bus.funct3[0] & bus.op_b[D_WIDTH-1];
    end else begin
      neg_a = (bus.funct3[1:0] != 2'b11) & bus.op_a[D_WIDTH-1];
      neg_b = ~bus.funct3[1] & bus.op_b[D_WIDTH-1];
    end
    mag_a = neg_a ? -bus.op_a : bus.op_a;
    mag_b = neg_b ? -bus.op_b : bus.op_b;
  end

  // One iteration: acc holds {partial product, multiplier} or {remainder, quotient}
  logic [D_WIDTH:0]   mul_sum;
  logic [D_WIDTH:0]   div_shift;
  logic               div_ge;
  logic [D_WIDTH-1:0] div_diff;
  logic [P_WIDTH-1:0] acc_step;

  always_comb begin
    mul_sum   = {1'b0, acc[P_WIDTH-1:D_WIDTH]} + (acc[0] ? {1'b0, opnd} : '0);
    div_shift = acc[P_WIDTH-1:D_WIDTH-1];
    div_ge    = div_shift >= {1'b0, opnd};
    div_diff  = div_shift[D_WIDTH-1:0] - opnd;
    if (op[2]) begin
      acc_step = {(div_ge ? div_diff : div_shift[D_WIDTH-1:0]), acc[D_WIDTH-2:0], div_ge};
    end else begin
      acc_step = {mul_sum, acc[D_WIDTH-1:1]};
    end
  end

  // Sign fix-up and result selection from the last iteration
  logic               res_neg;
  logic [P_WIDTH-1:0] prod_s;
  logic [D_WIDTH-1:0] quot;
  logic [D_WIDTH-1:0] rmd;
  logic [D_WIDTH-1:0] fin;

  always_comb begin
    res_neg = sign_a ^ sign_b;
    prod_s  = res_neg ? -acc_step : acc_step;
    quot    = acc_step[D_WIDTH-1:0];
    rmd     = acc_step[P_WIDTH-1:D_WIDTH];
    fin     = '0;
    case (op)
      3'b000:                 fin = prod_s[D_WIDTH-1:0];
      3'b001, 3'b010, 3'b011: fin = prod_s[P_WIDTH-1:D_WIDTH];
      3'b100, 3'b101:         fin = b_zero ? '1 : (res_neg ? -quot : quot);
      default:                fin = sign_a ? -rmd : rmd;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      count       <= '0;
      op          <= '0;
      sign_a      <= 1'b0;
      sign_b      <= 1'b0;
      b_zero      <= 1'b0;
      opnd        <= '0;
      acc         <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      reg_write_q <= 1'b0;
      result_q    <= '0;
      rd_q        <= '0;
    end else begin
      done_q      <= 1'b0;
      reg_write_q <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start && !bus.flush) begin
            state  <= CALC;
            busy_q <= 1'b1;
            count  <= '0;
            op     <= bus.funct3;
            sign_a <= neg_a;
            sign_b <= neg_b;
            b_zero <= (bus.op_b == '0);
            opnd   <= is_div ? mag_b : mag_a;
            acc    <= {{D_WIDTH{1'b0}}, (is_div ? mag_a : mag_b)};
            rd_q   <= bus.rd_in;
          end
        end
        CALC: begin
          if (bus.flush) begin
            state  <= IDLE;
            busy_q <= 1'b0;
          end else begin
            acc   <= acc_step;
            count <= count + CNT_W'(1);
            if (count == CNT_W'(D_WIDTH - 1)) begin
              state       <= DONE;
              result_q    <= fin;
              done_q      <= 1'b1;
              reg_write_q <= (rd_q != A_WIDTH'(0));
            end
          end
        end
        default: begin
          state  <= IDLE;
          busy_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.reg_write = reg_write_q;
  assign bus.result    = result_q;
  assign bus.rd_out    = rd_q;
endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit: directed RV32M vectors, latency, flush, reset and
// back-to-back behaviour, with a monitor checking every completion against queued expectations.
`timescale 1ns/1ps
module tb_muldiv_unit;
  logic        clk;
  logic        rst_n;
  int unsigned cyc;
  int unsigned n_chk;
  int unsigned n_fail;
  int unsigned n_done;

  typedef struct {
    logic [31:0] res;
    logic [4:0]  rd;
    logic        rw;
    int unsigned cyc;
    string       name;
  } exp_t;

  exp_t exp_q[$];

  muldiv_unit_if #(.D_WIDTH(32), .A_WIDTH(5)) bus ();

  muldiv_unit #(.D_WIDTH(32), .A_WIDTH(5)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endfunction

  // Monitor: pop one expectation per completion pulse
  always @(negedge clk) begin
    if (rst_n && bus.done) begin
      exp_t e;
      n_done++;
      if (exp_q.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL unexpected_done: got done=1 at cycle %0d, expected no completion", cyc);
      end else begin
        e = exp_q.pop_front();
        check({e.name, "_result"}, bus.result, e.res);
        check({e.name, "_rd"}, 32'(bus.rd_out), 32'(e.rd));
        check({e.name, "_reg_write"}, 32'(bus.reg_write), 32'(e.rw));
        check({e.name, "_latency"}, cyc, e.cyc);
      end
    end
  end

  task automatic drive(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] rd);
    bus.start  = 1'b1;
    bus.funct3 = f3;
    bus.op_a   = a;
    bus.op_b   = b;
    bus.rd_in  = rd;
  endtask

  // Issue one op, optionally queue its expectation, and wait until the unit is idle again
  task automatic issue(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] rd, input logic [31:0] res, input string name);
    exp_t e;
    @(negedge clk);
    drive(f3, a, b, rd);
    e.res  = res;
    e.rd   = rd;
    e.rw   = (rd != 5'd0);
    e.cyc  = cyc + 33;
    e.name = name;
    exp_q.push_back(e);
    @(negedge clk);
    bus.start = 1'b0;
    repeat (33) @(negedge clk);
  endtask

  initial begin
    exp_t        e;
    int unsigned done_snap;
    logic [31:0] res_snap;

    cyc        = 0;
    n_chk      = 0;
    n_fail     = 0;
    n_done     = 0;
    rst_n      = 1'b0;
    bus.start  = 1'b0;
    bus.flush  = 1'b0;
    bus.funct3 = 3'b000;
    bus.op_a   = '0;
    bus.op_b   = '0;
    bus.rd_in  = '0;

    #1;
    check("reset_busy", 32'(bus.busy), 32'd0);
    check("reset_done", 32'(bus.done), 32'd0);
    check("reset_result", bus.result, 32'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    issue(3'b000, 32'd7, 32'd6, 5'd5, 32'd42, "mul_7x6");
    issue(3'b001, 32'h8000_0000, 32'h8000_0000, 5'd1, 32'h4000_0000, "mulh_min");
    issue(3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd2, 32'hFFFF_FFFE, "mulhu_max");
    issue(3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd3, 32'hFFFF_FFFF, "mulhsu_neg1");
    issue(3'b100, 32'hFFFF_FFF9, 32'd2, 5'd4, 32'hFFFF_FFFD, "div_m7_2");
    issue(3'b110, 32'hFFFF_FFF9, 32'd2, 5'd6, 32'hFFFF_FFFF, "rem_m7_2");
    issue(3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 5'd7, 32'h8000_0000, "div_ovf");
    issue(3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 5'd8, 32'd0, "rem_ovf");
    issue(3'b101, 32'd13, 32'd0, 5'd10, 32'hFFFF_FFFF, "divu_by0");
    issue(3'b111, 32'd13, 32'd0, 5'd11, 32'd13, "remu_by0");
    issue(3'b100, 32'hFFFF_FFF9, 32'd0, 5'd12, 32'hFFFF_FFFF, "div_neg_by0");
    issue(3'b110, 32'hFFFF_FFF9, 32'd0, 5'd13, 32'hFFFF_FFF9, "rem_neg_by0");
    issue(3'b000, 32'd100, 32'd3, 5'd0, 32'd300, "mul_rd0");

    // Flush at CALC cycle 10: no completion, result keeps its value
    done_snap = n_done;
    res_snap  = 32'd300;
    @(negedge clk);
    drive(3'b000, 32'd5, 32'd5, 5'd3);
    @(negedge clk);
    bus.start = 1'b0;
    repeat (8) @(negedge clk);
    check("flush_busy_mid", 32'(bus.busy), 32'd1);
    @(negedge clk);
    bus.flush = 1'b1;
    @(negedge clk);
    bus.flush = 1'b0;
    repeat (40) @(negedge clk);
    check("flush_no_done", n_done, done_snap);
    check("flush_result_held", bus.result, res_snap);
    check("flush_idle", 32'(bus.busy), 32'd0);

    // Start held through busy: ignored until the cycle after DONE
    @(negedge clk);
    drive(3'b000, 32'd11, 32'd12, 5'd14);
    e.res = 32'd132; e.rd = 5'd14; e.rw = 1'b1; e.cyc = cyc + 33; e.name = "b2b_first";
    exp_q.push_back(e);
    @(negedge clk);
    bus.start = 1'b0;
    repeat (9) @(negedge clk);
    drive(3'b101, 32'd100, 32'd7, 5'd15);
    e.res = 32'd14; e.rd = 5'd15; e.rw = 1'b1; e.cyc = cyc + 24 + 33; e.name = "b2b_second";
    exp_q.push_back(e);
    repeat (25) @(negedge clk);
    bus.start = 1'b0;
    repeat (40) @(negedge clk);
    check("b2b_all_done", 32'(exp_q.size()), 32'd0);

    // Reset mid-CALC: outputs clear immediately and nothing is written back
    done_snap = n_done;
    @(negedge clk);
    drive(3'b000, 32'd9, 32'd9, 5'd16);
    @(negedge clk);
    bus.start = 1'b0;
    repeat (9) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_done", 32'(bus.done), 32'd0);
    check("rst_reg_write", 32'(bus.reg_write), 32'd0);
    check("rst_result", bus.result, 32'd0);
    check("rst_rd_out", 32'(bus.rd_out), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (40) @(negedge clk);
    check("rst_no_done", n_done, done_snap);

    issue(3'b111, 32'd100, 32'd7, 5'd17, 32'd2, "remu_after_rst");

    repeat (5) @(negedge clk);
    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
